// File: rtl/smc_pkg.sv
// Shared definitions for the SMC I2C register interface: register map,
// STAT bit layout and pointer-FSM state encoding.
package smc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WADDR = 2'd1,
        ST_WDATA = 2'd2,
        ST_RD    = 2'd3
    } state_t;

    // Per-channel addresses; element n belongs to channel n (ch0 = keyboard).
    localparam logic [1:0][7:0] ADDR_BUF  = {8'h21, 8'h07};
    localparam logic [1:0][7:0] ADDR_STAT = {8'h22, 8'h18};
    localparam logic [1:0][7:0] ADDR_CMD  = {8'h23, 8'h19};
    localparam logic [7:0]      ADDR_FLUSH = 8'h1F;
    localparam logic [7:0]      ADDR_VER   = 8'h30;

    localparam int STAT_OVF   = 7;
    localparam int STAT_BUSY  = 6;
    localparam int STAT_DROP  = 5;
    localparam int STAT_EMPTY = 4;

    function automatic logic [7:0] stat_byte(input logic ovf, input logic busy,
                                             input logic drop, input logic empty);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_OVF]   = ovf;
        s[STAT_BUSY]  = busy;
        s[STAT_DROP]  = drop;
        s[STAT_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/smc_fifo.sv
// Scancode FIFO with simultaneous push/pop, single-cycle flush and a
// registered non-empty flag used directly as the channel interrupt.
module smc_fifo
    import smc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk6x,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             nonempty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             full;
    logic             pop_eff;
    logic             push_eff;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop into an empty FIFO is ignored even if a push lands in the same cycle.
    assign pop_eff  = pop && !empty && !flush;
    assign push_eff = push && !flush && (!full || pop_eff);
    assign overflow = push && !flush && full && !pop_eff;

    assign head = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            unique case ({push_eff, pop_eff})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk6x) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            nonempty <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_eff) wr_ptr <= wr_ptr + 1'b1;
                if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            nonempty <= (count_next != '0);
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale data is never visible.
    always_ff @(posedge clk6x) begin
        if (push_eff) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/smc_regif.sv
// I2C-slave register front end for up to two PS2 channels: register pointer
// FSM, per-channel scancode FIFOs, command hand-off and status registers.
module smc_regif
    import smc_pkg::*;
#(
    parameter int         NCH        = 2,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] VERSION    = 8'h01
) (
    input  logic             clk6x,
    input  logic             reset,
    input  logic             devsel_i,
    input  logic             rw_bit_i,
    input  logic [7:0]       rxbyte_i,
    input  logic             rxbyte_v_i,
    output logic [7:0]       txbyte_o,
    input  logic             txbyte_deq_i,
    input  logic [8*NCH-1:0] ps2_rx_data_i,
    input  logic [NCH-1:0]   ps2_rx_v_i,
    output logic [8*NCH-1:0] ps2_tx_data_o,
    output logic [NCH-1:0]   ps2_tx_v_o,
    input  logic [NCH-1:0]   ps2_tx_rdy_i,
    output logic [NCH-1:0]   irq_o
);
    state_t     state;
    logic [7:0] regptr;
    logic       wr_stb;
    logic       rd_stb;

    logic [NCH-1:0][7:0] ch_head;
    logic [NCH-1:0][7:0] ch_stat;

    assign wr_stb = (state == ST_WDATA) && devsel_i && rxbyte_v_i;
    assign rd_stb = (state == ST_RD) && devsel_i && txbyte_deq_i;

    // regptr survives the end of a transaction so a repeated-start read reuses it.
    always_ff @(posedge clk6x) begin
        if (reset) begin
            state  <= ST_IDLE;
            regptr <= 8'h00;
        end else if (!devsel_i) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  state <= rw_bit_i ? ST_RD : ST_WADDR;
                ST_WADDR: begin
                    if (rxbyte_v_i) begin
                        regptr <= rxbyte_i;
                        state  <= ST_WDATA;
                    end
                end
                ST_WDATA: state <= ST_WDATA;
                ST_RD:    state <= ST_RD;
            endcase
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic       pop;
        logic       flush;
        logic       stat_rd;
        logic       cmd_wr;
        logic       overflow;
        logic       nonempty;
        logic       empty;
        logic [7:0] head;
        logic       ovf;
        logic       drop;
        logic       tx_v;
        logic [7:0] tx_data;

        assign pop     = rd_stb && (regptr == ADDR_BUF[n]);
        assign stat_rd = rd_stb && (regptr == ADDR_STAT[n]);
        assign cmd_wr  = wr_stb && (regptr == ADDR_CMD[n]);
        assign flush   = wr_stb && (regptr == ADDR_FLUSH) && rxbyte_i[n];

        smc_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (8)
        ) u_fifo (
            .clk6x     (clk6x),
            .reset     (reset),
            .push      (ps2_rx_v_i[n]),
            .push_data (ps2_rx_data_i[8*n +: 8]),
            .pop       (pop),
            .flush     (flush),
            .head      (head),
            .empty     (empty),
            .nonempty  (nonempty),
            .overflow  (overflow)
        );

        // A fresh overflow wins over a same-cycle STAT read so the event is not lost.
        always_ff @(posedge clk6x) begin
            if (reset) begin
                ovf     <= 1'b0;
                drop    <= 1'b0;
                tx_v    <= 1'b0;
                tx_data <= 8'h00;
            end else begin
                if (flush)         ovf <= 1'b0;
                else if (overflow) ovf <= 1'b1;
                else if (stat_rd)  ovf <= 1'b0;

                if (cmd_wr && tx_v) drop <= 1'b1;
                else if (stat_rd)   drop <= 1'b0;

                if (tx_v) begin
                    if (ps2_tx_rdy_i[n]) tx_v <= 1'b0;
                end else if (cmd_wr) begin
                    tx_data <= rxbyte_i;
                    tx_v    <= 1'b1;
                end
            end
        end

        assign ps2_tx_v_o[n]            = tx_v;
        assign ps2_tx_data_o[8*n +: 8]  = tx_data;
        assign irq_o[n]                 = nonempty;
        assign ch_head[n]               = head;
        assign ch_stat[n]               = stat_byte(ovf, tx_v, drop, empty);
    end

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        txbyte_o = 8'h00;
        if (regptr == ADDR_VER) txbyte_o = VERSION;
        for (int n = 0; n < NCH; n++) begin
            if (regptr == ADDR_BUF[n])  txbyte_o = ch_head[n];
            if (regptr == ADDR_STAT[n]) txbyte_o = ch_stat[n];
        end
    end

endmodule

// File: tb/tb_smc_regif.sv
// Directed bench for smc_regif: reset-state register table followed by
// hand-written sequences for FIFO, overflow, command, flush and reset cases.
`timescale 1ns/1ps
module tb_smc_regif;

    logic        clk6x = 1'b0;
    logic        reset;
    logic        devsel_i;
    logic        rw_bit_i;
    logic [7:0]  rxbyte_i;
    logic        rxbyte_v_i;
    logic [7:0]  txbyte_o;
    logic        txbyte_deq_i;
    logic [15:0] ps2_rx_data_i;
    logic [1:0]  ps2_rx_v_i;
    logic [15:0] ps2_tx_data_o;
    logic [1:0]  ps2_tx_v_o;
    logic [1:0]  ps2_tx_rdy_i;
    logic [1:0]  irq_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [9];

    smc_regif #(
        .NCH        (2),
        .FIFO_DEPTH (16),
        .VERSION    (8'h01)
    ) dut (
        .clk6x         (clk6x),
        .reset         (reset),
        .devsel_i      (devsel_i),
        .rw_bit_i      (rw_bit_i),
        .rxbyte_i      (rxbyte_i),
        .rxbyte_v_i    (rxbyte_v_i),
        .txbyte_o      (txbyte_o),
        .txbyte_deq_i  (txbyte_deq_i),
        .ps2_rx_data_i (ps2_rx_data_i),
        .ps2_rx_v_i    (ps2_rx_v_i),
        .ps2_tx_data_o (ps2_tx_data_o),
        .ps2_tx_v_o    (ps2_tx_v_o),
        .ps2_tx_rdy_i  (ps2_tx_rdy_i),
        .irq_o         (irq_o)
    );

    always #10 clk6x = ~clk6x;

    task automatic tick();
        @(posedge clk6x);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        ps2_rx_data_i[8*ch +: 8] = d;
        ps2_rx_v_i[ch] = 1'b1;
        tick();
        ps2_rx_v_i = 2'b00;
    endtask

    task automatic set_ptr(input logic [7:0] a);
        devsel_i = 1'b1; rw_bit_i = 1'b0;
        tick();
        rxbyte_i = a; rxbyte_v_i = 1'b1;
        tick();
        rxbyte_v_i = 1'b0; devsel_i = 1'b0;
        tick();
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        devsel_i = 1'b1; rw_bit_i = 1'b0;
        tick();
        rxbyte_i = a; rxbyte_v_i = 1'b1;
        tick();
        rxbyte_i = d;
        tick();
        rxbyte_v_i = 1'b0; devsel_i = 1'b0;
        tick();
    endtask

    task automatic rd_begin();
        devsel_i = 1'b1; rw_bit_i = 1'b1;
        tick();
    endtask

    task automatic rd_end();
        devsel_i = 1'b0; rw_bit_i = 1'b0;
        tick();
    endtask

    task automatic rd_expect(input string name, input logic [7:0] exp);
        check(name, {8'h00, txbyte_o}, {8'h00, exp});
        txbyte_deq_i = 1'b1;
        tick();
        txbyte_deq_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h07, 8'h00};
        vecs[1] = '{8'h18, 8'h10};
        vecs[2] = '{8'h19, 8'h00};
        vecs[3] = '{8'h1F, 8'h00};
        vecs[4] = '{8'h21, 8'h00};
        vecs[5] = '{8'h22, 8'h10};
        vecs[6] = '{8'h23, 8'h00};
        vecs[7] = '{8'h30, 8'h01};
        vecs[8] = '{8'h55, 8'h00};

        reset = 1'b1; devsel_i = 1'b0; rw_bit_i = 1'b0; rxbyte_i = 8'h00;
        rxbyte_v_i = 1'b0; txbyte_deq_i = 1'b0; ps2_rx_data_i = 16'h0000;
        ps2_rx_v_i = 2'b00; ps2_tx_rdy_i = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        check("reset_tx_v", {14'd0, ps2_tx_v_o}, 16'h0000);
        check("reset_tx_data", ps2_tx_data_o, 16'h0000);
        check("reset_irq", {14'd0, irq_o}, 16'h0000);
        check("reset_txbyte", {8'h00, txbyte_o}, 16'h0000);

        for (int i = 0; i < 9; i++) begin
            set_ptr(vecs[i].addr);
            check($sformatf("reg_%02h", vecs[i].addr), {8'h00, txbyte_o}, {8'h00, vecs[i].exp});
        end

        // Keyboard scancodes popped through BUF.
        push(0, 8'h1C); push(0, 8'hF0); push(0, 8'h1C);
        check("kbd_irq_set", {15'd0, irq_o[0]}, 16'h0001);
        set_ptr(8'h07);
        rd_begin();
        rd_expect("kbd_rd0", 8'h1C);
        rd_expect("kbd_rd1", 8'hF0);
        check("kbd_irq_hold", {15'd0, irq_o[0]}, 16'h0001);
        rd_expect("kbd_rd2", 8'h1C);
        check("kbd_irq_fall", {15'd0, irq_o[0]}, 16'h0000);
        rd_expect("kbd_rd3_empty", 8'h00);
        rd_end();

        // Mouse overflow: 17 bytes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) push(1, 8'(8'h40 + i));
        set_ptr(8'h22);
        rd_begin();
        rd_expect("ms_stat_ovf", 8'h80);
        check("ms_stat_clr", {8'h00, txbyte_o}, 16'h0000);
        rd_end();
        set_ptr(8'h21);
        rd_begin();
        for (int i = 0; i < 16; i++) rd_expect($sformatf("ms_rd%0d", i), 8'(8'h40 + i));
        check("ms_empty", {8'h00, txbyte_o}, 16'h0000);
        rd_end();

        // Command hand-off with a dropped second command.
        push(0, 8'h55);
        wr_reg(8'h19, 8'hED);
        check("cmd_v_set", {14'd0, ps2_tx_v_o}, 16'h0001);
        check("cmd_data", ps2_tx_data_o, 16'h00ED);
        wr_reg(8'h19, 8'h02);
        check("cmd_data_held", ps2_tx_data_o, 16'h00ED);
        set_ptr(8'h18);
        check("cmd_stat_busy_drop", {8'h00, txbyte_o}, 16'h0060);
        ps2_tx_rdy_i = 2'b01;
        tick();
        ps2_tx_rdy_i = 2'b00;
        check("cmd_v_drop", {14'd0, ps2_tx_v_o}, 16'h0000);
        check("cmd_stat_drop_only", {8'h00, txbyte_o}, 16'h0020);
        rd_begin();
        rd_expect("cmd_stat_rd", 8'h20);
        check("cmd_stat_cleared", {8'h00, txbyte_o}, 16'h0000);
        rd_end();

        // Full FIFO with same-cycle push and pop.
        for (int i = 0; i < 15; i++) push(0, 8'(8'h60 + i));
        set_ptr(8'h07);
        rd_begin();
        check("full_head", {8'h00, txbyte_o}, 16'h0055);
        ps2_rx_data_i[7:0] = 8'hAA; ps2_rx_v_i = 2'b01; txbyte_deq_i = 1'b1;
        tick();
        ps2_rx_v_i = 2'b00; txbyte_deq_i = 1'b0;
        for (int i = 0; i < 15; i++) rd_expect($sformatf("full_rd%0d", i), 8'(8'h60 + i));
        rd_expect("full_last_aa", 8'hAA);
        check("full_drained", {8'h00, txbyte_o}, 16'h0000);
        rd_end();
        set_ptr(8'h18);
        check("full_no_ovf", {8'h00, txbyte_o}, 16'h0010);

        // Flush both channels, with a push on ch0 in the flush cycle.
        push(0, 8'hB1);
        for (int i = 0; i < 17; i++) push(1, 8'(8'hB2 + i));
        check("flush_irq_pre", {14'd0, irq_o}, 16'h0003);
        set_ptr(8'h22);
        check("flush_ovf_pre", {8'h00, txbyte_o}, 16'h0080);
        devsel_i = 1'b1; rw_bit_i = 1'b0;
        tick();
        rxbyte_i = 8'h1F; rxbyte_v_i = 1'b1;
        tick();
        rxbyte_i = 8'h03; ps2_rx_data_i[7:0] = 8'hC3; ps2_rx_v_i = 2'b01;
        tick();
        rxbyte_v_i = 1'b0; ps2_rx_v_i = 2'b00; devsel_i = 1'b0;
        check("flush_irq", {14'd0, irq_o}, 16'h0000);
        tick();
        set_ptr(8'h18);
        check("flush_stat0", {8'h00, txbyte_o}, 16'h0010);
        set_ptr(8'h22);
        check("flush_stat1", {8'h00, txbyte_o}, 16'h0010);
        set_ptr(8'h07);
        check("flush_buf0", {8'h00, txbyte_o}, 16'h0000);
        set_ptr(8'h30);
        check("version", {8'h00, txbyte_o}, 16'h0001);

        // Reset in the middle of a BUF read with a command pending.
        push(0, 8'h11); push(0, 8'h22);
        wr_reg(8'h19, 8'h9A);
        check("rst_cmd_pending", {14'd0, ps2_tx_v_o}, 16'h0001);
        set_ptr(8'h07);
        rd_begin();
        check("rst_head", {8'h00, txbyte_o}, 16'h0011);
        txbyte_deq_i = 1'b1; reset = 1'b1;
        tick();
        txbyte_deq_i = 1'b0; reset = 1'b0; devsel_i = 1'b0; rw_bit_i = 1'b0;
        check("rst_tx_v", {14'd0, ps2_tx_v_o}, 16'h0000);
        check("rst_tx_data", ps2_tx_data_o, 16'h0000);
        check("rst_irq", {14'd0, irq_o}, 16'h0000);
        check("rst_txbyte", {8'h00, txbyte_o}, 16'h0000);
        tick();
        set_ptr(8'h18);
        check("rst_stat0", {8'h00, txbyte_o}, 16'h0010);
        set_ptr(8'h07);
        check("rst_buf0", {8'h00, txbyte_o}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
